// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width, divider FSM states and the
// quotient value reported for a division by zero.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  // Divider control states, fixed two-bit encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  // Quotient returned when the divisor is zero.
  localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider8_div_step.sv
// One restoring-division step.
// The partial remainder and the next dividend bit are shifted together into a
// trial value T. The divisor is then subtracted from T with the same
// invert-and-carry-in adder used by the ALU add/subtract unit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;

  // Trial subtraction, then restore T when the difference is negative.
  always_comb begin
    // r_i is always below the divisor, and it is built from at most WIDTH-1
    // dividend bits before the last shift. Its MSB is therefore 0 here, so
    // {r_i, bit} equals the (WIDTH+1)-bit trial value.
    t       = {r_i, q_msb_i};
    diff    = t + ~{1'b0, divisor_i} + (WIDTH + 1)'(1);
    q_bit_o = ~diff[WIDTH];
    r_o     = q_bit_o ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider8.sv
// Multi-cycle restoring divider with a start/busy/done handshake.
// It produces one quotient bit per clock.
// Optional macro SEQ_DIVIDER8_SIGNED_EN selects two's-complement operands.
// In that mode the core divides the magnitudes, and one extra FINISH cycle
// fixes up the signs of the results.
module seq_divider8
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;  // captured divisor
  logic             dz_q, dz_d;      // divide-by-zero for the operation in flight
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dzo_q, dzo_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
`ifdef SEQ_DIVIDER8_SIGNED_EN
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             fix_q, fix_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[WIDTH-1]),
    .divisor_i (dvsr_q),
    .r_o       (step_r),
    .q_bit_o   (step_q)
  );

  // Operand magnitudes fed to the unsigned core.
  always_comb begin
`ifdef SEQ_DIVIDER8_SIGNED_EN
    dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    dividend_mag = dividend;
    divisor_mag  = divisor;
`endif
  end

  // Next-state logic for the FSM, the datapath and the result registers.
  always_comb begin
    // NOTE: every signal gets a hold value first. Any path that leaves one
    // unassigned would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    done_d  = 1'b0;
`ifdef SEQ_DIVIDER8_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    fix_d      = fix_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The done cycle still belongs to the finishing operation, so a start
        // seen while done is high is dropped.
        if (start && !done_q) begin
          if (divisor == '0) begin
            q_d     = DIV_ZERO_QUOT;
            r_d     = dividend;
            dz_d    = 1'b1;
            cnt_d   = '0;
            state_d = FINISH;
`ifdef SEQ_DIVIDER8_SIGNED_EN
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
`endif
          end else begin
            q_d     = dividend_mag;
            r_d     = '0;
            dvsr_d  = divisor_mag;
            dz_d    = 1'b0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = RUN;
`ifdef SEQ_DIVIDER8_SIGNED_EN
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
`endif
          end
        end
      end
      RUN: begin
        r_d   = step_r;
        q_d   = {q_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
`ifdef SEQ_DIVIDER8_SIGNED_EN
        if (!fix_q) begin
          fix_d = 1'b1;
          if (neg_quot_q) q_d = -q_q;
          if (neg_rem_q)  r_d = -r_q;
        end else begin
          fix_d   = 1'b0;
          quot_d  = q_q;
          rem_d   = r_q;
          dzo_d   = dz_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`else
        quot_d  = q_q;
        rem_d   = r_q;
        dzo_d   = dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath and result registers are reset too, not only the
    // FSM. The outputs must read zero as soon as reset hits.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_DIVIDER8_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      fix_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values held before this edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
      done_q  <= done_d;
`ifdef SEQ_DIVIDER8_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      fix_q      <= fix_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8.
// It applies a table of directed vectors, then hand-written handshake and
// reset sequences, then a random sweep. Results are compared against an
// arithmetic reference model.
// Optional macro SEQ_DIVIDER8_SIGNED_EN selects the signed expectations.
module tb_seq_divider8;

  localparam int WIDTH = 8;
`ifdef SEQ_DIVIDER8_SIGNED_EN
  localparam int LAT    = WIDTH + 3;  // cycles from start to the done cycle
  localparam int LAT_DZ = 3;
`else
  localparam int LAT    = WIDTH + 2;
  localparam int LAT_DZ = 2;
`endif
  localparam int MAX_WAIT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend, divisor;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs [8];

  seq_divider8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference results from plain arithmetic.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz);
`ifdef SEQ_DIVIDER8_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == 8'd0) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER8_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      dz = 1'b0;
    end
  endfunction

  // Called at a negedge: waits for done, counting cycles from that point.
  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      if (done) begin
        k = i;
        break;
      end
    end
  endtask

  // Called at a negedge: pulses start for one cycle and waits for done.
  // On return the bench sits at the negedge of the done cycle.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    lat      = 0;
    busy_cnt = 0;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, bcnt, w;
    logic [7:0] eq, er, a, b;
    logic edz;

`ifdef SEQ_DIVIDER8_SIGNED_EN
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, LAT};
    vecs[1] = '{8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, LAT};
    vecs[2] = '{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, LAT};
    vecs[3] = '{8'd42,  8'd0,   8'hFF,  8'd42,  1'b1, LAT_DZ};
    vecs[4] = '{8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, LAT};
    vecs[5] = '{8'hF9,  8'hFE,  8'h03,  8'hFF,  1'b0, LAT};
    vecs[6] = '{8'h80,  8'h01,  8'h80,  8'h00,  1'b0, LAT};
    vecs[7] = '{8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, LAT};
`else
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, LAT};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, LAT};
    vecs[2] = '{8'd5,   8'd200, 8'd0,   8'd5,   1'b0, LAT};
    vecs[3] = '{8'd42,  8'd0,   8'hFF,  8'd42,  1'b1, LAT_DZ};
    vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, LAT};
    vecs[5] = '{8'd200, 8'd201, 8'd0,   8'd200, 1'b0, LAT};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, LAT};
    vecs[7] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, LAT};
`endif

    // Reset state.
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_outputs", {quotient, remainder, 7'd0, div_by_zero}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      do_div(vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      check($sformatf("vec%0d_div_by_zero", i), 32'(div_by_zero), 32'(vecs[i].dz));
      if (i == 0) check("vec0_busy_cycles", 32'(bcnt), WIDTH);
      @(negedge clk);
    end

    // A start issued mid-RUN is ignored, and the results hold during RUN.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_during_run", {quotient, remainder}, {vecs[7].q, vecs[7].r});
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk); start = 1'b0;
    wait_done(w);
    check("midrun_latency", 32'(w == 0 ? 0 : w + 4), LAT);
    check("midrun_result", {quotient, remainder}, {8'd14, 8'd2});

    // A start in the done cycle is dropped; one a cycle later is taken.
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    check("start_in_done_ignored", 32'(busy), 0);
    check("result_stable_after_done", {quotient, remainder}, {8'd14, 8'd2});
    do_div(8'd9, 8'd3, lat, bcnt);
    check("after_done_latency", 32'(lat), LAT);
    check("after_done_result", {quotient, remainder}, {8'd3, 8'd0});
    @(negedge clk);

    // Reset during the fourth cycle of a divide clears everything at once.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_outputs", {quotient, remainder, 6'd0, done, div_by_zero}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 0);
    do_div(8'd100, 8'd7, lat, bcnt);
    check("post_rst_latency", 32'(lat), LAT);
    check("post_rst_result", {quotient, remainder}, {8'd14, 8'd2});
    @(negedge clk);

    // Random sweep against the reference model.
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      model(a, b, eq, er, edz);
      do_div(a, b, lat, bcnt);
      check($sformatf("rand%0d_%0h_%0h", i, a, b), {quotient, remainder, 7'd0, div_by_zero},
            {eq, er, 7'd0, edz});
      check($sformatf("rand%0d_latency", i), 32'(lat), LAT);
`ifndef SEQ_DIVIDER8_SIGNED_EN
      check($sformatf("rand%0d_invariant", i),
            32'((int'(quotient) * int'(b) + int'(remainder) == int'(a)) && (remainder < b)), 1);
`endif
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
